fifo_port_master: RTL

- Initiator for the team's single-port FIFO (shared wnr/en/in/out/full/empty interface; one write or one read per clock).
- Splits that interface into an upstream producer stream (valid/ready) and a downstream consumer stream (valid/ready).
- Arbitrates the shared FIFO port each cycle.
- Absorbs the FIFO's one-cycle registered read latency with a 2-entry output skid buffer.

---
 rtl/fifo_port_master.sv | 107 ++++++++++
 1 files changed

// File: rtl/fifo_port_master.sv
`default_nettype none
// ============================================================================
// Module      : fifo_port_master
// Description : Initiator for a single-port FIFO (shared wnr/en/in/out port).
//               Splits the port into a valid/ready producer stream and a
//               valid/ready consumer stream. A priority bit arbitrates the
//               shared port each cycle. A 2-entry skid buffer absorbs the
//               FIFO's one-cycle registered read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_port_master #(
    parameter int BUS_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [BUS_WIDTH-1:0] s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [BUS_WIDTH-1:0] m_data,
    input  logic                 m_ready,
    output logic                 fifo_wnr,
    output logic                 fifo_en,
    output logic [BUS_WIDTH-1:0] fifo_in,
    input  logic [BUS_WIDTH-1:0] fifo_out,
    input  logic                 fifo_full,
    input  logic                 fifo_empty
);

    // Arbitration and skid-buffer state
    logic                 r_prio;     // 0: write preferred, 1: read preferred
    logic                 r_rd_pend;  // read issued last cycle, data on fifo_out now
    logic                 r_head;     // index of oldest buffered word
    logic [1:0]           r_occ;      // buffered words, 0..2
    logic [BUS_WIDTH-1:0] r_buf [2];

    logic       w_pop;
    logic [2:0] w_level;
    logic       w_space;
    logic       w_read_want;
    logic       w_write_ok;
    logic       w_contend;
    logic       w_rd_issue;
    logic       w_tail;

    // Consumer side: the buffer head is always presented
    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_buf[r_head];
    assign w_pop   = m_valid && m_ready;

    // Words that will be held once everything already in flight lands; a new
    // read is only allowed if its word is guaranteed a free slot.
    assign w_level     = {1'b0, r_occ} - {2'b00, w_pop} + {2'b00, r_rd_pend};
    assign w_space     = (w_level < 3'd2);
    assign w_read_want = !fifo_empty && w_space;
    assign w_write_ok  = !fifo_full;

    // s_ready deliberately ignores s_valid so there is no comb loop upstream
    assign s_ready   = w_write_ok && !(w_read_want && r_prio);
    assign w_contend = s_valid && w_write_ok && w_read_want;
    assign fifo_in   = s_data;

    // Capture slot sits occ entries past the head (mod 2)
    assign w_tail = r_head ^ r_occ[0];

    // Issue at most one FIFO operation per cycle; nothing is issued in reset
    always_comb begin
        fifo_en  = 1'b0;
        fifo_wnr = 1'b0;
        if (!rst) begin
            if (s_valid && s_ready) begin
                fifo_en  = 1'b1;
                fifo_wnr = 1'b1;
            end else if (w_read_want) begin
                fifo_en  = 1'b1;
            end
        end
    end

    assign w_rd_issue = fifo_en && !fifo_wnr;

    // Priority, read-pending tracking and skid-buffer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_rd_pend <= 1'b0;
            r_head    <= 1'b0;
            r_occ     <= 2'd0;
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
        end else begin
            if (w_contend) begin
                r_prio <= !r_prio;
            end
            r_rd_pend <= w_rd_issue;
            if (r_rd_pend) begin
                r_buf[w_tail] <= fifo_out;
            end
            if (w_pop) begin
                r_head <= !r_head;
            end
            r_occ <= r_occ + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
